// File: rtl/uart_tx_fifo_cfg.sv
// UART transmitter with a small TX FIFO and per-frame configurable format
// (5-8 data bits, optional even/odd parity, 1 or 2 stop bits).
module uart_tx_fifo_cfg #(
    parameter int OVS        = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        tick,
    input  logic                        wr_valid,
    input  logic [7:0]                  wr_data,
    output logic                        wr_ready,
    input  logic [1:0]                  cfg_data_bits,
    input  logic                        cfg_parity_en,
    input  logic                        cfg_parity_odd,
    input  logic                        cfg_stop2,
    output logic                        tx,
    output logic                        tx_busy,
    output logic                        frame_done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic [2:0]                  dbg_state
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = (OVS > 1) ? $clog2(OVS) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    // Handshake: a byte is taken on any rising edge where wr_valid && wr_ready;
    // wr_ready depends on occupancy only, so it never reacts to wr_valid.
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    state_t        state;
    logic [TW-1:0] tick_cnt;
    logic [7:0]    sh;
    logic [2:0]    bit_idx;
    logic [2:0]    n_last;
    logic          par_en_r;
    logic          par_bit;
    logic          stop2_r;
    logic          stop_idx;

    logic          push;
    logic          pop;
    logic          bit_end;
    logic          last_stop;
    logic [7:0]    head;
    logic [7:0]    mask;

    assign wr_ready   = count < CW'(FIFO_DEPTH);
    assign fifo_count = count;
    assign dbg_state  = state;
    assign push       = wr_valid && wr_ready;
    assign bit_end    = tick && (tick_cnt == TW'(OVS - 1));
    assign last_stop  = (state == STOP) && bit_end && (!stop2_r || stop_idx);
    assign pop        = (count != '0) && ((state == IDLE) || last_stop);
    assign head       = mem[rd_ptr];
    assign mask       = 8'hFF >> (2'd3 - cfg_data_bits);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tx         <= 1'b1;
            tx_busy    <= 1'b0;
            frame_done <= 1'b0;
            tick_cnt   <= '0;
            sh         <= '0;
            bit_idx    <= '0;
            n_last     <= '0;
            par_en_r   <= 1'b0;
            par_bit    <= 1'b0;
            stop2_r    <= 1'b0;
            stop_idx   <= 1'b0;
        end else begin
            frame_done <= last_stop;
            if (state != IDLE && tick) begin
                tick_cnt <= bit_end ? '0 : tick_cnt + TW'(1);
            end
            // Pop covers both the idle start and the gapless stop-to-start case;
            // the whole frame format is captured here and held until the next pop.
            if (pop) begin
                state    <= START;
                tx       <= 1'b0;
                tx_busy  <= 1'b1;
                tick_cnt <= '0;
                sh       <= head;
                n_last   <= {1'b0, cfg_data_bits} + 3'd4;
                par_en_r <= cfg_parity_en;
                par_bit  <= (^(head & mask)) ^ cfg_parity_odd;
                stop2_r  <= cfg_stop2;
            end else begin
                case (state)
                    IDLE: begin
                        tx_busy <= 1'b0;
                    end
                    START: begin
                        if (bit_end) begin
                            state   <= DATA;
                            tx      <= sh[0];
                            bit_idx <= '0;
                        end
                    end
                    DATA: begin
                        if (bit_end) begin
                            if (bit_idx == n_last) begin
                                stop_idx <= 1'b0;
                                if (par_en_r) begin
                                    state <= PARITY;
                                    tx    <= par_bit;
                                end else begin
                                    state <= STOP;
                                    tx    <= 1'b1;
                                end
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                                sh      <= sh >> 1;
                                tx      <= sh[1];
                            end
                        end
                    end
                    PARITY: begin
                        if (bit_end) begin
                            state    <= STOP;
                            tx       <= 1'b1;
                            stop_idx <= 1'b0;
                        end
                    end
                    STOP: begin
                        if (last_stop) begin
                            state   <= IDLE;
                            tx      <= 1'b1;
                            tx_busy <= 1'b0;
                        end else if (bit_end) begin
                            stop_idx <= 1'b1;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        tx      <= 1'b1;
                        tx_busy <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo_cfg.sv
// Bench for uart_tx_fifo_cfg: a line monitor checks every frame bit-by-bit
// against expected frames from a table or from a frame-building model.
module tb_uart_tx_fifo_cfg;
    localparam int OVS = 16;
    localparam int FD  = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                tick;
    logic                wr_valid;
    logic [7:0]          wr_data;
    logic                wr_ready;
    logic [1:0]          cfg_data_bits;
    logic                cfg_parity_en;
    logic                cfg_parity_odd;
    logic                cfg_stop2;
    logic                tx;
    logic                tx_busy;
    logic                frame_done;
    logic [$clog2(FD):0] fifo_count;
    logic [2:0]          dbg_state;

    uart_tx_fifo_cfg #(.OVS(OVS), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .tick(tick), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready), .cfg_data_bits(cfg_data_bits), .cfg_parity_en(cfg_parity_en),
        .cfg_parity_odd(cfg_parity_odd), .cfg_stop2(cfg_stop2), .tx(tx), .tx_busy(tx_busy),
        .frame_done(frame_done), .fifo_count(fifo_count), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] bits;
        int          len;
    } frame_t;

    typedef struct {
        logic [7:0] data;
        logic [1:0] dbits;
        logic       pen;
        logic       podd;
        logic       stop2;
        string      seq;
    } vec_t;

    frame_t exp_frames[$];
    vec_t   vecs[5];
    int     errors = 0;
    int     checks = 0;
    int     frames_expected = 0;

    logic        in_frame = 1'b0;
    logic        prev_tx = 1'b1;
    logic        expect_done = 1'b0;
    logic        just_ended = 1'b0;
    int          tick_idx = 0;
    int          mism = 0;
    int          frames_seen = 0;
    int          spurious_done = 0;
    int          b2b_starts = 0;
    frame_t      cur;
    logic [11:0] got_bits;

    function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endfunction

    function automatic frame_t seq2frame(string s);
        frame_t f;
        f.bits = '0;
        f.len  = s.len();
        for (int i = 0; i < s.len(); i++) f.bits[i] = (s.getc(i) == 8'h31);
        return f;
    endfunction

    // Frame = start 0, N data bits LSB first, optional parity, one or two 1s.
    function automatic frame_t model_frame(logic [7:0] d, logic [1:0] db, logic pen,
                                           logic podd, logic st2);
        frame_t     f;
        int         n = int'(db) + 5;
        int         k = 0;
        logic [7:0] m = 8'((1 << n) - 1);
        f.bits = '0;
        f.bits[k] = 1'b0; k++;
        for (int i = 0; i < n; i++) begin
            f.bits[k] = d[i]; k++;
        end
        if (pen) begin
            f.bits[k] = (($countones(d & m) % 2) == 1) ^ podd; k++;
        end
        f.bits[k] = 1'b1; k++;
        if (st2) begin
            f.bits[k] = 1'b1; k++;
        end
        f.len = k;
        return f;
    endfunction

    // Tick source: irregular spacing, sometimes on consecutive cycles.
    initial begin
        int gap = 0;
        tick = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (gap == 0) begin
                tick = 1'b1;
                gap  = $urandom_range(0, 2);
            end else begin
                tick = 1'b0;
                gap--;
            end
        end
    end

    // Line monitor: tx sampled at every tick must match the expected bit for OVS ticks.
    always @(negedge clk) begin
        if (rst) begin
            in_frame    = 1'b0;
            expect_done = 1'b0;
            just_ended  = 1'b0;
            exp_frames.delete();
        end else begin
            if (expect_done) begin
                check("frame_done", frame_done, 1);
                expect_done = 1'b0;
            end else if (frame_done) begin
                spurious_done++;
            end
            if (!in_frame && prev_tx && !tx) begin
                if (just_ended) b2b_starts++;
                if (exp_frames.size() == 0) begin
                    check("unexpected_frame", 1, 0);
                end else begin
                    cur      = exp_frames.pop_front();
                    in_frame = 1'b1;
                    tick_idx = 0;
                    mism     = 0;
                    got_bits = '0;
                end
            end
            just_ended = 1'b0;
            if (in_frame && tick) begin
                if (tx !== cur.bits[tick_idx / OVS]) mism++;
                if (!tx_busy) mism++;
                if (tick_idx % OVS == OVS / 2) got_bits[tick_idx / OVS] = tx;
                tick_idx++;
                if (tick_idx == OVS * cur.len) begin
                    in_frame    = 1'b0;
                    expect_done = 1'b1;
                    just_ended  = 1'b1;
                    frames_seen++;
                    checks++;
                    if (mism != 0) begin
                        errors++;
                        $display("FAIL frame %0d: got bits %b expected %b (%0d bad samples)",
                                 frames_seen, got_bits, cur.bits, mism);
                    end
                end
            end
        end
        prev_tx = tx;
    end

    task automatic set_cfg(input logic [1:0] db, input logic pen, input logic podd,
                           input logic st2);
        cfg_data_bits  = db;
        cfg_parity_en  = pen;
        cfg_parity_odd = podd;
        cfg_stop2      = st2;
    endtask

    task automatic push_byte(input logic [7:0] d, input frame_t f);
        int n = 0;
        while (!wr_ready && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) begin
            check("wr_ready_timeout", 0, 1);
        end else begin
            exp_frames.push_back(f);
            frames_expected++;
            wr_valid = 1'b1;
            wr_data  = d;
            @(negedge clk);
            wr_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_frames.size() != 0 || in_frame || tx_busy || expect_done) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("drain_in_time", n < 20000, 1);
        check("idle_tx", tx, 1);
        check("idle_busy", tx_busy, 0);
    endtask

    task automatic wait_mid(input int ticks);
        int n = 0;
        while (!(in_frame && tick_idx >= ticks) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("reach_mid_frame", n < 20000, 1);
    endtask

    initial begin
        int     b2b0;
        int     sp0;
        frame_t f;
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_data  = '0;
        set_cfg(2'd3, 1'b0, 1'b0, 1'b0);

        vecs[0] = '{8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, "0101001011"};
        vecs[1] = '{8'h53, 2'd2, 1'b1, 1'b0, 1'b1, "01100101011"};
        vecs[2] = '{8'hFF, 2'd0, 1'b1, 1'b1, 1'b0, "01111101"};
        vecs[3] = '{8'h3C, 2'd1, 1'b0, 1'b0, 1'b1, "000111111"};
        vecs[4] = '{8'h00, 2'd3, 1'b1, 1'b1, 1'b0, "00000000011"};

        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_done", frame_done, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ready", wr_ready, 1);
        check("rst_state", dbg_state, 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        foreach (vecs[i]) begin
            set_cfg(vecs[i].dbits, vecs[i].pen, vecs[i].podd, vecs[i].stop2);
            push_byte(vecs[i].data, seq2frame(vecs[i].seq));
            wait_drain();
        end

        // Five writes on consecutive cycles into an idle 4-deep FIFO.
        set_cfg(2'd3, 1'b0, 1'b0, 1'b0);
        b2b0 = b2b_starts;
        for (int i = 0; i < 5; i++) begin
            f = model_frame(8'h10 + 8'(i), 2'd3, 1'b0, 1'b0, 1'b0);
            push_byte(8'h10 + 8'(i), f);
        end
        check("burst_count", fifo_count, 4);
        check("burst_ready", wr_ready, 0);
        wr_valid = 1'b1;
        wr_data  = 8'hEE;
        @(negedge clk);
        wr_valid = 1'b0;
        check("full_write_count", fifo_count, 4);
        wait_drain();
        check("back_to_back", b2b_starts - b2b0, 4);

        // Stop-bit count changed mid-frame only affects the next frame.
        push_byte(8'h96, model_frame(8'h96, 2'd3, 1'b0, 1'b0, 1'b0));
        push_byte(8'h69, model_frame(8'h69, 2'd3, 1'b0, 1'b0, 1'b1));
        wait_mid(2 * OVS + 3);
        cfg_stop2 = 1'b1;
        wait_drain();
        cfg_stop2 = 1'b0;

        // Reset in DATA with two bytes queued, plus a write during reset.
        for (int i = 0; i < 3; i++) begin
            push_byte(8'hC0 + 8'(i), model_frame(8'hC0 + 8'(i), 2'd3, 1'b0, 1'b0, 1'b0));
        end
        wait_mid(3 * OVS + 4);
        sp0      = spurious_done;
        rst      = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 8'h77;
        @(negedge clk);
        wr_valid = 1'b0;
        check("abort_tx", tx, 1);
        check("abort_busy", tx_busy, 0);
        check("abort_count", fifo_count, 0);
        check("abort_done", frame_done, 0);
        @(negedge clk);
        rst = 1'b0;
        frames_expected -= 3;
        repeat (400) @(negedge clk);
        check("post_abort_count", fifo_count, 0);
        check("post_abort_tx", tx, 1);
        check("post_abort_no_done", spurious_done - sp0, 0);

        // Random formats and bursts against the frame model.
        for (int b = 0; b < 6; b++) begin
            logic [1:0] db;
            logic       pen;
            logic       podd;
            logic       st2;
            int         nb;
            db   = 2'($urandom_range(0, 3));
            pen  = 1'($urandom_range(0, 1));
            podd = 1'($urandom_range(0, 1));
            st2  = 1'($urandom_range(0, 1));
            set_cfg(db, pen, podd, st2);
            nb = $urandom_range(1, 6);
            for (int i = 0; i < nb; i++) begin
                logic [7:0] d;
                d = 8'($urandom);
                push_byte(d, model_frame(d, db, pen, podd, st2));
            end
            wait_drain();
        end

        check("frames_seen", frames_seen, frames_expected);
        check("spurious_done", spurious_done, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo_cfg.md
UART_TX_FIFO_CFG -- requirements
Module: uart_tx_fifo_cfg

Interface
REQ-001 SHALL have parameter OVS, default 16, giving oversample ticks per bit (range 4-32).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, giving the TX FIFO depth (power of 2, range 2-64).
REQ-003 SHALL have port clk, input, 1 bit: the clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port tick, input, 1 bit: one-clk-wide pulse at OVS x baud rate.
REQ-006 SHALL have port wr_valid, input, 1 bit: write request.
REQ-007 SHALL have port wr_data, input, 8 bits: byte to send; when fewer than 8 data bits are configured, only the LSBs are sent.
REQ-008 SHALL have port wr_ready, output, 1 bit: asserted when the FIFO is not full.
REQ-009 SHALL have port cfg_data_bits, input, 2 bits: 0 = 5, 1 = 6, 2 = 7, 3 = 8 data bits.
REQ-010 SHALL have port cfg_parity_en, input, 1 bit: enables the parity bit.
REQ-011 SHALL have port cfg_parity_odd, input, 1 bit: 1 = odd parity, 0 = even parity.
REQ-012 SHALL have port cfg_stop2, input, 1 bit: 1 = two stop bits, 0 = one stop bit.
REQ-013 SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-014 SHALL have port tx_busy, output, 1 bit: a frame is in progress.
REQ-015 SHALL have port frame_done, output, 1 bit: one-clk pulse at the end of each frame.
REQ-016 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits: current FIFO occupancy.

Function
REQ-017 A write SHALL be accepted on a clk edge with wr_valid && wr_ready; wr_ready is combinational from occupancy only: ready = count < FIFO_DEPTH, with no bypass.
REQ-018 The FIFO SHALL be first-in first-out, with pointers wrapping modulo FIFO_DEPTH; a push and a pop in the same cycle SHALL leave fifo_count unchanged.
REQ-019 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-020 In IDLE with count > 0: pop the head entry, latch all cfg_* inputs and the data, drive tx <= 0 and tx_busy <= 1, clear tick_cnt, and go to START; tx goes low one clk after the pop decision.
REQ-021 Every bit period SHALL last exactly OVS tick pulses; a bit advances on (tick && tick_cnt == OVS-1), otherwise tick_cnt increments on each tick.
REQ-022 START -> DATA: tx = data[0], and subsequent bits follow LSB first, for N = 5..8 bits.
REQ-023 DATA -> PARITY after N bits if parity is enabled; otherwise DATA -> STOP.
REQ-024 The parity bit SHALL be the XOR of the N data bits, inverted when cfg_parity_odd = 1.
REQ-025 STOP SHALL drive tx = 1 for 1 or 2 bit periods, per the latched cfg_stop2.
REQ-026 At the end of STOP: pulse frame_done for one clk; if count > 0, pop immediately, latch the new config, drive tx <= 0, and go to START, keeping tx_busy = 1 with no idle gap; otherwise go to IDLE with tx_busy <= 0.
REQ-027 A cfg_* change mid-frame SHALL NOT affect the current frame.
REQ-028 tick SHALL be ignored in IDLE, and the tick count SHALL NOT be pre-counted.
REQ-029 A write to a full FIFO (wr_ready = 0) SHALL NOT modify the FIFO contents.
REQ-030 Cycles between tick pulses SHALL hold the state and tx.

Reset
REQ-031 While rst is asserted: tx = 1, tx_busy = 0, frame_done = 0, fifo_count = 0, wr_ready = 1, state = IDLE, tick_cnt = 0, and pointers = 0.
REQ-032 Reset asserted mid-frame SHALL abort the frame: tx = 1 on the next edge, FIFO contents discarded, and no frame_done pulse.
REQ-033 Reset SHALL take priority over every simultaneous event, including a write accept.

Verification
REQ-034 8N1 (OVS = 16), write 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit held 16 ticks; frame_done pulses once; tx_busy spans 160 ticks.
REQ-035 7 data bits, even parity, 2 stop bits, write 0x53 -> tx sequence 0,1,1,0,0,1,0,1,0,1,1 (parity = 0), 176 ticks total.
REQ-036 5 data bits, odd parity, write 0xFF -> data bits 1,1,1,1,1, parity 0, frame 8 bits long.
REQ-037 Write 5 bytes back-to-back into FIFO_DEPTH = 4 while idle -> wr_ready drops once count = 4 (the first byte popped frees one slot); frames are back-to-back with no idle high between stop and start; data is received in order.
REQ-038 rst asserted in the middle of the DATA state with 2 bytes queued -> tx = 1, fifo_count = 0, tx_busy = 0 on the next clk; no frame_done.
REQ-039 cfg_stop2 toggled during the DATA state -> the current frame keeps its latched stop count, and the next frame uses the new value.
